mips_mc_controller: RTL and testbench
=====================================

Name: mips_mc_controller

Overview:
- Multicycle MIPS control FSM. Sequences a shared-memory multicycle datapath (single memory port for instruction and data) across FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK steps.
- Replaces the combinational single-cycle controller in the multicycle core variant.
- Adds a memory request/ready handshake and a memory-timeout watchdog.

Parameters:
- MEM_TIMEOUT, 255: maximum wait cycles per memory access before abort. Legal range 1..255; the counter is 8 bits.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- op  in  6  instr[31:26] from IR
- funct  in  6  instr[5:0] from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access active
- iord  out  1  0 = address from PC, 1 = address from ALUOut
- memwrite  out  1  store strobe
- irwrite  out  1  IR load enable
- pcen  out  1  PC load enable
- regwrite  out  1  register-file write
- alusrca  out  1  0 = PC, 1 = A register
- alusrcb  out  2  00 = B, 01 = constant 4, 10 = signimm, 11 = signimm<<2
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- memtoreg  out  2  00 = ALUOut, 01 = Data register, 10 = PC (link)
- regdst  out  2  00 = rt, 01 = rd, 10 = $31
- alucontrol  out  5  AND 00000, OR 00001, ADD 00010, SUB 00110, SLT 00111
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct
- mem_err  out  1  one-cycle pulse on memory timeout
- state  out  4  current state (debug)

Behaviour:
- Reset:
  - On a reset clock edge: state becomes FETCH, wait counter 0, illegal 0, mem_err 0.
  - While reset is high: mem_req, memwrite, irwrite, pcen and regwrite are forced to 0.
- Outputs: all decoded from state, except the following, which are Mealy:
  - pcen and irwrite depend on mem_ready and zero.
  - The memory-state transitions depend on mem_ready.
- Defaults: every output not listed for a state is 0 and alucontrol is ADD.
- State encodings and actions:
  - FETCH (0): mem_req=1, iord=0, alusrca=0, alusrcb=01, pcsrc=00. When mem_ready=1: irwrite=1, pcen=1, go to DECODE. Otherwise stay.
  - DECODE (1): alusrca=0, alusrcb=11 (branch target into ALUOut). Next state by op:
    - 100011 (lw) and 101011 (sw) go to MEMADR.
    - 000000 (R-type) goes to RTYPEEX.
    - 000100 (beq) and 000101 (bne) go to BRANCHEX.
    - 001000 (addi) goes to ADDIEX.
    - 000010 (j) goes to JEX.
    - Any other op: pulse illegal, go to FETCH.
  - MEMADR (2): alusrca=1, alusrcb=10. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD (3): mem_req=1, iord=1. On mem_ready go to MEMWB.
  - MEMWB (4): regwrite=1, regdst=00, memtoreg=01. Go to FETCH.
  - MEMWR (5): mem_req=1, iord=1, memwrite=1. On mem_ready go to FETCH.
  - RTYPEEX (6): alusrca=1, alusrcb=00, alucontrol decoded from funct:
    - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
    - Supported funct goes to ALUWB. Unsupported funct: pulse illegal, go to FETCH, no register write.
  - ALUWB (7): regwrite=1, regdst=01, memtoreg=00. Go to FETCH.
  - BRANCHEX (8): alusrca=1, alusrcb=00, alucontrol=SUB, pcsrc=01. pcen = zero for beq, ~zero for bne. Go to FETCH.
  - ADDIEX (9): alusrca=1, alusrcb=10. Go to ADDIWB.
  - ADDIWB (10): regwrite=1, regdst=00, memtoreg=00. Go to FETCH.
  - JEX (11): pcsrc=10, pcen=1. Go to FETCH.
- Watchdog:
  - Wait counter clears on entry to FETCH, MEMRD or MEMWR.
  - It increments each cycle mem_req=1 and mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: pulse mem_err, drop mem_req the next cycle, go to FETCH.
  - A fetch that times out leaves PC and IR unchanged, so the fetch is retried.
- Boundary cases:
  - mem_ready on the very cycle the count reaches MEM_TIMEOUT: the access completes normally and there is no mem_err.
  - mem_ready=1 outside mem_req states is ignored.
  - Reset mid-access abandons the access. memwrite is 0 in the cycle after the reset edge.
- Latency with zero wait states:
  - lw 5 cycles.
  - sw, R-type and addi 4 cycles.
  - beq, bne and j 3 cycles.
  - Each memory wait cycle adds 1.

Optional Feature:
- MIPS_MC_JAL_EN defined:
  - op 000011 (jal) goes from DECODE to JALEX (12).
  - JALEX: regwrite=1, regdst=10, memtoreg=10 (PC+4 already in PC), pcsrc=10, pcen=1, then FETCH.
  - jal takes 3 cycles.
- Undefined: op 000011 is illegal, and state 12 does not exist.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=0: outputs are state=0, mem_req=1, pcen=0, irwrite=0 until mem_ready=1. Then irwrite=pcen=1 for exactly one cycle and state=1.
- lw (op=100011), mem_ready always 1: state sequence 0,1,2,3,4,0. regwrite=1 only in state 4, with memtoreg=01, regdst=00.
- R-type funct=100010 then funct=111111:
  - 100010: alucontrol=00110 in state 6, regwrite in state 7.
  - 111111: illegal pulses once, states 0,1,6,0, regwrite never asserted.
- beq with zero=1 gives pcen=1 and pcsrc=01 in state 8. bne with zero=1 gives pcen=0. bne with zero=0 gives pcen=1.
- sw with MEM_TIMEOUT=4 and mem_ready held 0: memwrite=1 for 4 cycles in state 5, mem_err pulses once, next state 0. The same case with mem_ready=1 in wait cycle 4 gives no mem_err.
- op=000011: with MIPS_MC_JAL_EN, states 0,1,12,0 with regwrite=1, regdst=10, memtoreg=10, pcen=1. Without it, illegal=1 and return to state 0.

Source files
------------

// File: rtl/mips_mc_controller_if.sv
// mips_mc_controller_if
//   Bundles the control bus between the multicycle MIPS controller and its
//   datapath/memory.
//   master : controller side. It drives the control strobes, the memory request
//            and the debug state. It receives the IR fields, the ALU zero flag
//            and mem_ready.
//   slave  : datapath/memory side, with the opposite directions.
//
//   Memory handshake: mem_req is high for every cycle an access is
//   outstanding. An access completes in the first cycle where mem_req and
//   mem_ready are both high. mem_ready is ignored while mem_req is low.
//   iord/memwrite qualify the access while mem_req is high.
interface mips_mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       pcen;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] memtoreg;
  logic [1:0] regdst;
  logic [4:0] alucontrol;
  logic       illegal;
  logic       mem_err;
  logic [3:0] state;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, iord, memwrite, irwrite, pcen, regwrite, alusrca, alusrcb,
           pcsrc, memtoreg, regdst, alucontrol, illegal, mem_err, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, iord, memwrite, irwrite, pcen, regwrite, alusrca, alusrcb,
           pcsrc, memtoreg, regdst, alucontrol, illegal, mem_err, state
  );
endinterface

// File: rtl/mips_mc_controller.sv
// mips_mc_controller
//   Multicycle MIPS control FSM for a datapath with a single shared memory
//   port. It steps through fetch, decode, execute, memory and writeback. It
//   also runs a watchdog that aborts any memory access still waiting after
//   MEM_TIMEOUT cycles.
//   Ports: clk, reset (synchronous, active-high), bus (mips_mc_controller_if
//          master). The bus carries the IR fields, zero, the mem_req/mem_ready
//          handshake, the datapath controls, the illegal/mem_err pulses and
//          the debug state.
//   Parameter: MEM_TIMEOUT (1..255), the maximum wait cycles per access.
//   Build option: define MIPS_MC_JAL_EN to add jal (op 000011, JALEX state 12).
//                 When it is undefined, jal is decoded as illegal.
module mips_mc_controller #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_mc_controller_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPEEX  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCHEX = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JEX      = 4'd11
`ifdef MIPS_MC_JAL_EN
    , S_JALEX  = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_MC_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;

  // The count of a waiting access reaches MEM_TIMEOUT in the cycle where the
  // registered count still holds MEM_TIMEOUT-1.
  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       illegal_q, illegal_d;
  logic       mem_err_q, mem_err_d;

  logic       req_c, iord_c, memwrite_c, irwrite_c, pcen_c, regwrite_c;
  logic       alusrca_c;
  logic [1:0] alusrcb_c, pcsrc_c, memtoreg_c, regdst_c;
  logic [4:0] alucontrol_c;
  logic       access_live, mem_done, mem_expire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    illegal_d    = 1'b0;
    mem_err_d    = 1'b0;
    req_c        = 1'b0;
    iord_c       = 1'b0;
    memwrite_c   = 1'b0;
    irwrite_c    = 1'b0;
    pcen_c       = 1'b0;
    regwrite_c   = 1'b0;
    alusrca_c    = 1'b0;
    alusrcb_c    = 2'b00;
    pcsrc_c      = 2'b00;
    memtoreg_c   = 2'b00;
    regdst_c     = 2'b00;
    alucontrol_c = ALU_ADD;

    // The cycle after an abort is a FETCH with mem_req dropped. That cycle
    // neither counts nor completes, so the retried fetch starts clean.
    access_live = ((state_q == S_FETCH) || (state_q == S_MEMRD) ||
                   (state_q == S_MEMWR)) && !mem_err_q;
    mem_done    = access_live && bus.mem_ready;
    mem_expire  = access_live && !bus.mem_ready && (wait_cnt_q == LAST_WAIT);

    case (state_q)
      S_FETCH: begin
        req_c     = 1'b1;
        alusrcb_c = 2'b01;
        if (mem_done) begin
          irwrite_c = 1'b1;
          pcen_c    = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb_c = 2'b11;
        case (bus.op)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_RTYPE:        state_d = S_RTYPEEX;
          OP_BEQ, OP_BNE:  state_d = S_BRANCHEX;
          OP_ADDI:         state_d = S_ADDIEX;
          OP_J:            state_d = S_JEX;
`ifdef MIPS_MC_JAL_EN
          OP_JAL:          state_d = S_JALEX;
`endif
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_d   = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        req_c  = 1'b1;
        iord_c = 1'b1;
        if (mem_done) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg_c = 2'b01;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        req_c      = 1'b1;
        iord_c     = 1'b1;
        memwrite_c = 1'b1;
        if (mem_done) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca_c = 1'b1;
        state_d   = S_ALUWB;
        case (bus.funct)
          6'b100000: alucontrol_c = ALU_ADD;
          6'b100010: alucontrol_c = ALU_SUB;
          6'b100100: alucontrol_c = ALU_AND;
          6'b100101: alucontrol_c = ALU_OR;
          6'b101010: alucontrol_c = ALU_SLT;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        regwrite_c = 1'b1;
        regdst_c   = 2'b01;
        state_d    = S_FETCH;
      end
      S_BRANCHEX: begin
        alusrca_c    = 1'b1;
        alucontrol_c = ALU_SUB;
        pcsrc_c      = 2'b01;
        pcen_c       = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
        state_d      = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_JEX: begin
        pcsrc_c = 2'b10;
        pcen_c  = 1'b1;
        state_d = S_FETCH;
      end
`ifdef MIPS_MC_JAL_EN
      S_JALEX: begin
        regwrite_c = 1'b1;
        regdst_c   = 2'b10;
        memtoreg_c = 2'b10;
        pcsrc_c    = 2'b10;
        pcen_c     = 1'b1;
        state_d    = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // The watchdog overrides the state's own transition. A timed-out fetch
    // never asserted irwrite/pcen, so it simply re-runs from FETCH.
    if (mem_expire) begin
      mem_err_d = 1'b1;
      state_d   = S_FETCH;
    end

    if (mem_expire || (state_d != state_q)) begin
      wait_cnt_d = '0;
    end else if (access_live && !bus.mem_ready) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  assign bus.mem_req    = req_c & ~mem_err_q & ~reset;
  assign bus.memwrite   = memwrite_c & ~reset;
  assign bus.irwrite    = irwrite_c & ~reset;
  assign bus.pcen       = pcen_c & ~reset;
  assign bus.regwrite   = regwrite_c & ~reset;
  assign bus.iord       = iord_c;
  assign bus.alusrca    = alusrca_c;
  assign bus.alusrcb    = alusrcb_c;
  assign bus.pcsrc      = pcsrc_c;
  assign bus.memtoreg   = memtoreg_c;
  assign bus.regdst     = regdst_c;
  assign bus.alucontrol = alucontrol_c;
  assign bus.illegal    = illegal_q;
  assign bus.mem_err    = mem_err_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller
//   Random instruction stream for the multicycle controller, using random
//   memory wait states and timeouts. A sequence-level model expands each
//   instruction into its expected per-cycle outputs (state plus every control
//   signal packed into one word) together with the per-cycle inputs to drive.
module tb_mips_mc_controller;
  localparam int TO = 4;
  localparam int W  = 26;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [4:0] A_AND = 5'b00000, A_OR = 5'b00001, A_ADD = 5'b00010;
  localparam logic [4:0] A_SUB = 5'b00110, A_SLT = 5'b00111;

  logic clk = 1'b0;
  logic reset;
  mips_mc_controller_if bus ();

  mips_mc_controller #(.MEM_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  logic [13:0]  stim_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic       pend_ill = 1'b0;
  logic [5:0] cur_op = '0;
  logic [5:0] cur_funct = '0;
  logic       cur_zero = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] obs();
    return {bus.state, bus.mem_req, bus.iord, bus.memwrite, bus.irwrite, bus.pcen,
            bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.memtoreg,
            bus.regdst, bus.alucontrol, bus.illegal, bus.mem_err};
  endfunction

  function automatic logic [19:0] mk(input logic req, iord, mw, irw, pcen, rw, asa,
                                     input logic [1:0] asb, pcs, m2r, rdst,
                                     input logic [4:0] aluc);
    return {req, iord, mw, irw, pcen, rw, asa, asb, pcs, m2r, rdst, aluc};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Wait cycles before mem_ready: mostly none, sometimes up to the timeout
  // boundary (TO-1 completes on the last allowed cycle, TO times out).
  function automatic int rand_wait();
    int r = int'($urandom_range(0, 9));
    if (r < 6) return 0;
    if (r < 8) return int'($urandom_range(1, TO - 2));
    if (r == 8) return TO - 1;
    return TO;
  endfunction

  function automatic bit alu_of(input logic [5:0] f, output logic [4:0] a);
    a = A_ADD;
    case (f)
      6'b100000: a = A_ADD;
      6'b100010: a = A_SUB;
      6'b100100: a = A_AND;
      6'b100101: a = A_OR;
      6'b101010: a = A_SLT;
      default:   return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic emit(input logic [3:0] st, input logic [19:0] c, input logic rdy, input logic err);
    exp_q.push_back({st, c, pend_ill, err});
    stim_q.push_back({cur_op, cur_funct, cur_zero, rdy});
    pend_ill = 1'b0;
  endtask

  // kind 0 = fetch, 1 = load, 2 = store. w = wait cycles before mem_ready.
  task automatic do_access(input int kind, input int w, output bit aborted);
    logic rdy;
    aborted = 1'b0;
    for (int i = 0; i < TO; i++) begin
      rdy = (i == w);
      case (kind)
        0:       emit(4'd0, mk(1, 0, 0, rdy, rdy, 0, 0, 2'b01, 0, 0, 0, A_ADD), rdy, 1'b0);
        1:       emit(4'd3, mk(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, A_ADD), rdy, 1'b0);
        default: emit(4'd5, mk(1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, A_ADD), rdy, 1'b0);
      endcase
      if (rdy) return;
    end
    aborted = 1'b1;
    // After the abort: back in FETCH with the request dropped and mem_err set.
    emit(4'd0, mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, A_ADD), rbit(), 1'b1);
  endtask

  task automatic model_instr(input logic [5:0] op, input logic [5:0] funct, input logic z,
                             input int wf, input int wm);
    bit ab;
    int tries = 0;
    logic [4:0] a;
    cur_op = op; cur_funct = funct; cur_zero = z;
    do_access(0, wf, ab);
    while (ab) begin
      tries++;
      do_access(0, (tries >= 2) ? 0 : rand_wait(), ab);
    end
    emit(4'd1, mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, A_ADD), rbit(), 1'b0);
    case (op)
      OP_LW: begin
        emit(4'd2, mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, A_ADD), rbit(), 1'b0);
        do_access(1, wm, ab);
        if (!ab) emit(4'd4, mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 2'b01, 2'b00, A_ADD), rbit(), 1'b0);
      end
      OP_SW: begin
        emit(4'd2, mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, A_ADD), rbit(), 1'b0);
        do_access(2, wm, ab);
      end
      OP_R: begin
        if (alu_of(funct, a)) begin
          emit(4'd6, mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, a), rbit(), 1'b0);
          emit(4'd7, mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b01, A_ADD), rbit(), 1'b0);
        end else begin
          emit(4'd6, mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, A_ADD), rbit(), 1'b0);
          pend_ill = 1'b1;
        end
      end
      OP_BEQ, OP_BNE:
        emit(4'd8, mk(0, 0, 0, 0, (op == OP_BEQ) ? z : !z, 0, 1, 2'b00, 2'b01, 0, 0, A_SUB),
             rbit(), 1'b0);
      OP_ADDI: begin
        emit(4'd9, mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, A_ADD), rbit(), 1'b0);
        emit(4'd10, mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, A_ADD), rbit(), 1'b0);
      end
      OP_J: emit(4'd11, mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 0, 0, A_ADD), rbit(), 1'b0);
`ifdef MIPS_MC_JAL_EN
      OP_JAL: emit(4'd12, mk(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 2'b10, A_ADD), rbit(), 1'b0);
`endif
      default: pend_ill = 1'b1;
    endcase
  endtask

  // Apply one queued cycle at each falling edge and compare just after.
  task automatic run_q();
    logic [13:0]  s;
    logic [W-1:0] e;
    while (stim_q.size() > 0) begin
      @(negedge clk);
      s = stim_q.pop_front();
      reset = 1'b0;
      {bus.op, bus.funct, bus.zero, bus.mem_ready} = s;
      #1;
      e = exp_q.pop_front();
      check($sformatf("cycle %0d exp_state %0d", cyc, e[W-1 -: 4]), obs(), e);
      cyc++;
    end
  endtask

  logic [5:0] op_tab [9];
  logic [5:0] fn_tab [5];

  initial begin
    op_tab = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_JAL, OP_R};
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    reset = 1'b1;
    bus.op = OP_LW; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    // Held in reset with mem_ready high: FETCH, all strobes forced low.
    check("reset", obs(), {4'd0, mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, A_ADD), 2'b00});

    // Directed cases, then a random stream.
    model_instr(OP_LW, 6'h00, 1'b0, 3, 0);
    model_instr(OP_R, 6'b100010, 1'b0, 0, 0);
    model_instr(OP_R, 6'b111111, 1'b0, 0, 0);
    model_instr(OP_BEQ, 6'h00, 1'b1, 0, 0);
    model_instr(OP_BNE, 6'h00, 1'b1, 0, 0);
    model_instr(OP_BNE, 6'h00, 1'b0, 0, 0);
    model_instr(OP_BEQ, 6'h00, 1'b0, 0, 0);
    model_instr(OP_SW, 6'h00, 1'b0, 0, TO);
    model_instr(OP_SW, 6'h00, 1'b0, 0, TO - 1);
    model_instr(OP_LW, 6'h00, 1'b0, 0, TO);
    model_instr(OP_ADDI, 6'h00, 1'b0, TO, 0);
    model_instr(OP_JAL, 6'h00, 1'b0, 0, 0);
    model_instr(OP_J, 6'h00, 1'b0, 0, 0);
    model_instr(OP_ADDI, 6'h00, 1'b0, 1, 0);
    run_q();

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op, fn;
      int k = int'($urandom_range(0, 9));
      op = (k == 9) ? 6'($urandom) : op_tab[k];
      fn = ($urandom_range(0, 3) != 0) ? fn_tab[$urandom_range(0, 4)] : 6'($urandom);
      model_instr(op, fn, rbit(), rand_wait(), rand_wait());
      run_q();
    end

    // Store interrupted by reset while in MEMWR.
    cur_op = OP_SW; cur_funct = '0; cur_zero = 1'b0;
    begin
      bit ab;
      do_access(0, 0, ab);
    end
    emit(4'd1, mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, A_ADD), 1'b0, 1'b0);
    emit(4'd2, mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, A_ADD), 1'b0, 1'b0);
    run_q();
    @(negedge clk);
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("reset_in_memwr", W'({bus.state, bus.mem_req, bus.memwrite}), W'({4'd5, 2'b00}));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("after_reset", W'({bus.state, bus.mem_req, bus.memwrite, bus.iord}), W'({4'd0, 3'b100}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
